aplic_src_gateway: RTL and testbench

//  Parametrised interrupt-source front-end for the APLIC domain. Replaces the fixed 2-level synchronizer.
//  Per source, in order: a configurable-depth synchronizer, a glitch filter, and rectification per the

---
 rtl/aplic_pkg.sv | 33 +++
 rtl/aplic_src_filter.sv | 43 ++++
 rtl/aplic_src_gateway.sv | 71 +++++++
 tb/tb_aplic_src_gateway.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aplic_pkg.sv
// Shared APLIC types: per-source mode encoding and the helpers used to
// classify and rectify an interrupt source.
package aplic_pkg;

  typedef enum logic [2:0] {
    SM_INACTIVE = 3'd0,
    SM_DETACHED = 3'd1,
    SM_EDGE1    = 3'd4,
    SM_EDGE0    = 3'd5,
    SM_LEVEL1   = 3'd6,
    SM_LEVEL0   = 3'd7
  } src_mode_e;

  function automatic logic is_edge(src_mode_e m);
    return (m == SM_EDGE1) || (m == SM_EDGE0);
  endfunction

  function automatic logic is_level(src_mode_e m);
    return (m == SM_LEVEL1) || (m == SM_LEVEL0);
  endfunction

  // Reserved encodings 2 and 3 fall into the default and read as inactive.
  function automatic logic rectify(src_mode_e m, logic f);
    logic r;
    case (m)
      SM_EDGE1, SM_LEVEL1: r = f;
      SM_EDGE0, SM_LEVEL0: r = ~f;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aplic_src_filter.sv
// One interrupt source: configurable-depth synchronizer followed by a
// glitch filter that only accepts a new level after it has been stable.
module aplic_src_filter #(
  parameter int NrSyncLevels = 2,
  parameter int FilterW      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_irq,
  input  logic [FilterW-1:0] i_filter_len,
  output logic               o_filt
);

  logic [NrSyncLevels-1:0] sync_q;
  logic [FilterW-1:0]      cnt_q;
  logic                    f_q;
  logic                    s;

  assign s = sync_q[NrSyncLevels-1];

  // The >= compare lets a shrink of i_filter_len mid-count resolve at once;
  // cnt only increments while below i_filter_len, so it can never wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[NrSyncLevels-2:0], i_irq};
      if (s == f_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= i_filter_len) begin
        f_q   <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_filt = f_q;

endmodule

// File: rtl/aplic_src_gateway.sv
// APLIC interrupt-source front-end: per-source sync + filter, then mode
// rectification and registered level / edge set-pending requests.
module aplic_src_gateway
  import aplic_pkg::*;
#(
  parameter int NrSources    = 32,
  parameter int NrSyncLevels = 2,
  parameter int FilterW      = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NrSources-1:0]   i_irq_sources,
  input  logic [3*NrSources-1:0] i_sm,
  input  logic [FilterW-1:0]     i_filter_len,
  output logic [NrSources-1:0]   o_rectified,
  output logic [NrSources-1:0]   o_edge_req,
  output logic [NrSources-1:0]   o_level_req
);

  logic [NrSources-1:0]   filt;
  logic [NrSources-1:0]   rect;
  logic [NrSources-1:0]   edge_mode;
  logic [NrSources-1:0]   level_mode;
  logic [NrSources-1:0]   sm_same;
  logic [NrSources-1:0]   prev_q;
  logic [3*NrSources-1:0] sm_q;
  logic                   primed_q;

  for (genvar g = 0; g < NrSources; g++) begin : g_src
    src_mode_e sm_cur;

    aplic_src_filter #(
      .NrSyncLevels (NrSyncLevels),
      .FilterW      (FilterW)
    ) u_filter (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_irq        (i_irq_sources[g]),
      .i_filter_len (i_filter_len),
      .o_filt       (filt[g])
    );

    assign sm_cur        = src_mode_e'(i_sm[3*g +: 3]);
    assign rect[g]       = rectify(sm_cur, filt[g]);
    assign edge_mode[g]  = is_edge(sm_cur);
    assign level_mode[g] = is_level(sm_cur);
    assign sm_same[g]    = (i_sm[3*g +: 3] == sm_q[3*g +: 3]);
  end

  // A mode change suppresses the pulse for one cycle while prev reloads, so
  // switching modes alone never produces an edge; primed masks the EDGE0
  // rising edge that would otherwise appear right out of reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rectified <= '0;
      o_level_req <= '0;
      o_edge_req  <= '0;
      prev_q      <= '0;
      sm_q        <= '0;
      primed_q    <= 1'b0;
    end else begin
      o_rectified <= rect;
      o_level_req <= rect & level_mode;
      o_edge_req  <= edge_mode & rect & ~prev_q & sm_same & {NrSources{primed_q}};
      prev_q      <= rect;
      sm_q        <= i_sm;
      primed_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aplic_src_gateway.sv
// Self-checking bench for aplic_src_gateway: per-scenario tasks predict the
// per-cycle outputs into a scoreboard queue and compare as cycles complete.
module tb_aplic_src_gateway;
  import aplic_pkg::*;

  localparam int N  = 32;
  localparam int NS = 2;
  localparam int FW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   irq;
  logic [3*N-1:0] sm;
  logic [FW-1:0]  flen;
  logic [N-1:0]   o_rectified;
  logic [N-1:0]   o_edge_req;
  logic [N-1:0]   o_level_req;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int   cyc;
    int   src;
    logic rect;
    logic lvl;
    logic edg;
  } exp_t;

  exp_t sbq[$];

  aplic_src_gateway #(
    .NrSources    (N),
    .NrSyncLevels (NS),
    .FilterW      (FW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_irq_sources (irq),
    .i_sm          (sm),
    .i_filter_len  (flen),
    .o_rectified   (o_rectified),
    .o_edge_req    (o_edge_req),
    .o_level_req   (o_level_req)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cyc=%0d, required finish earlier", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_sm(input int src, input src_mode_e m);
    sm[3*src +: 3] = m;
  endtask

  task automatic push(input int c, input int s, input logic r, input logic l, input logic e);
    exp_t x;
    x.cyc = c; x.src = s; x.rect = r; x.lvl = l; x.edg = e;
    sbq.push_back(x);
  endtask

  task automatic clean_reset(input logic [FW-1:0] len);
    irq  = '0;
    sm   = '0;
    flen = len;
    rst  = 1'b1;
    repeat (2) tick();
    rst  = 1'b0;
    sbq.delete();
  endtask

  task automatic test_reset();
    irq  = '1;
    flen = '0;
    for (int i = 0; i < N; i++) set_sm(i, SM_EDGE0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({o_rectified, o_level_req, o_edge_req} !== '0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got rect=%h lvl=%h edge=%h required all 0",
                 cyc, o_rectified, o_level_req, o_edge_req);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      total++;
      if (o_edge_req !== '0) begin
        bad++;
        $display("FAIL reset_release_edge cyc=%0d got edge=%h required 0", cyc, o_edge_req);
      end
    end
  endtask

  task automatic test_edge_latency();
    int e;
    clean_reset(4'd0);
    set_sm(5, SM_EDGE1);
    repeat (3) tick();
    e = cyc;
    irq[5] = 1'b1;
    for (int c = e + 1; c <= e + 8; c++) push(c, 5, c >= e + 4, 1'b0, c == e + 4);
    for (int k = 0; k < 8; k++) begin
      tick();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t x;
        x = sbq.pop_front();
        total++;
        if (o_rectified[x.src] !== x.rect || o_level_req[x.src] !== x.lvl || o_edge_req[x.src] !== x.edg) begin
          bad++;
          $display("FAIL edge_latency cyc=%0d src=%0d got rect/lvl/edge=%b%b%b required %b%b%b",
                   cyc, x.src, o_rectified[x.src], o_level_req[x.src], o_edge_req[x.src], x.rect, x.lvl, x.edg);
        end
      end
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL edge_latency_drain got %0d left required 0", sbq.size());
    end
  endtask

  task automatic test_filter();
    int e;
    clean_reset(4'd3);
    set_sm(2, SM_LEVEL1);
    repeat (3) tick();
    e = cyc;
    irq[2] = 1'b1;
    for (int c = e + 1; c <= e + 12; c++) push(c, 2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cyc == e + 3) irq[2] = 1'b0;
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t x;
        x = sbq.pop_front();
        total++;
        if (o_rectified[x.src] !== x.rect || o_level_req[x.src] !== x.lvl || o_edge_req[x.src] !== x.edg) begin
          bad++;
          $display("FAIL filter_glitch cyc=%0d src=%0d got rect/lvl/edge=%b%b%b required %b%b%b",
                   cyc, x.src, o_rectified[x.src], o_level_req[x.src], o_edge_req[x.src], x.rect, x.lvl, x.edg);
        end
      end
    end
    e = cyc;
    irq[2] = 1'b1;
    for (int c = e + 1; c <= e + 14; c++)
      push(c, 2, (c >= e + 7) && (c <= e + 10), (c >= e + 7) && (c <= e + 10), 1'b0);
    for (int k = 0; k < 14; k++) begin
      tick();
      if (cyc == e + 4) irq[2] = 1'b0;
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t x;
        x = sbq.pop_front();
        total++;
        if (o_rectified[x.src] !== x.rect || o_level_req[x.src] !== x.lvl || o_edge_req[x.src] !== x.edg) begin
          bad++;
          $display("FAIL filter_accept cyc=%0d src=%0d got rect/lvl/edge=%b%b%b required %b%b%b",
                   cyc, x.src, o_rectified[x.src], o_level_req[x.src], o_edge_req[x.src], x.rect, x.lvl, x.edg);
        end
      end
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL filter_drain got %0d left required 0", sbq.size());
    end
  endtask

  task automatic test_level0();
    int e;
    clean_reset(4'd0);
    e = cyc;
    set_sm(7, SM_LEVEL0);
    for (int c = e + 1; c <= e + 6; c++) push(c, 7, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t x;
        x = sbq.pop_front();
        total++;
        if (o_rectified[x.src] !== x.rect || o_level_req[x.src] !== x.lvl || o_edge_req[x.src] !== x.edg) begin
          bad++;
          $display("FAIL level0 cyc=%0d src=%0d got rect/lvl/edge=%b%b%b required %b%b%b",
                   cyc, x.src, o_rectified[x.src], o_level_req[x.src], o_edge_req[x.src], x.rect, x.lvl, x.edg);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    int e;
    clean_reset(4'd0);
    set_sm(1, SM_LEVEL1);
    irq[1] = 1'b1;
    repeat (6) tick();
    e = cyc;
    set_sm(1, SM_EDGE1);
    for (int c = e + 1; c <= e + 5; c++) push(c, 1, 1'b1, 1'b0, 1'b0);
    e = e + 5;
    for (int c = e + 1; c <= e + 6; c++) push(c, 1, c < e + 4, 1'b0, 1'b0);
    e = e + 6;
    for (int c = e + 1; c <= e + 8; c++) push(c, 1, c >= e + 4, 1'b0, c == e + 4);
    for (int k = 0; k < 19; k++) begin
      tick();
      if (k == 4) irq[1] = 1'b0;
      if (k == 10) irq[1] = 1'b1;
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t x;
        x = sbq.pop_front();
        total++;
        if (o_rectified[x.src] !== x.rect || o_level_req[x.src] !== x.lvl || o_edge_req[x.src] !== x.edg) begin
          bad++;
          $display("FAIL mode_switch cyc=%0d src=%0d got rect/lvl/edge=%b%b%b required %b%b%b",
                   cyc, x.src, o_rectified[x.src], o_level_req[x.src], o_edge_req[x.src], x.rect, x.lvl, x.edg);
        end
      end
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL mode_switch_drain got %0d left required 0", sbq.size());
    end
  endtask

  task automatic test_reset_mid_filter();
    int e;
    int r;
    clean_reset(4'd7);
    set_sm(3, SM_EDGE1);
    repeat (3) tick();
    e = cyc;
    irq[3] = 1'b1;
    for (int c = e + 1; c <= e + 6; c++) push(c, 3, 1'b0, 1'b0, 1'b0);
    r = e + 7;
    for (int c = r + 1; c <= r + 14; c++) push(c, 3, c >= r + 11, 1'b0, c == r + 11);
    for (int k = 0; k < 21; k++) begin
      tick();
      if (cyc == e + 6) rst = 1'b1;
      if (cyc == r) begin
        rst = 1'b0;
        total++;
        if ({o_rectified, o_level_req, o_edge_req} !== '0) begin
          bad++;
          $display("FAIL mid_reset_clear cyc=%0d got rect=%h edge=%h required 0", cyc, o_rectified, o_edge_req);
        end
      end
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t x;
        x = sbq.pop_front();
        total++;
        if (o_rectified[x.src] !== x.rect || o_level_req[x.src] !== x.lvl || o_edge_req[x.src] !== x.edg) begin
          bad++;
          $display("FAIL mid_reset cyc=%0d src=%0d got rect/lvl/edge=%b%b%b required %b%b%b",
                   cyc, x.src, o_rectified[x.src], o_level_req[x.src], o_edge_req[x.src], x.rect, x.lvl, x.edg);
        end
      end
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_drain got %0d left required 0", sbq.size());
    end
  endtask

  task automatic test_back_to_back();
    int e;
    clean_reset(4'd0);
    set_sm(9, SM_EDGE1);
    repeat (3) tick();
    e = cyc;
    irq[9] = 1'b1;
    for (int c = e + 1; c <= e + 12; c++)
      push(c, 9, (c == e + 4) || (c == e + 5) || (c == e + 8) || (c == e + 9), 1'b0,
           (c == e + 4) || (c == e + 8));
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cyc == e + 2) irq[9] = 1'b0;
      if (cyc == e + 4) irq[9] = 1'b1;
      if (cyc == e + 6) irq[9] = 1'b0;
      while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t x;
        x = sbq.pop_front();
        total++;
        if (o_rectified[x.src] !== x.rect || o_level_req[x.src] !== x.lvl || o_edge_req[x.src] !== x.edg) begin
          bad++;
          $display("FAIL back_to_back cyc=%0d src=%0d got rect/lvl/edge=%b%b%b required %b%b%b",
                   cyc, x.src, o_rectified[x.src], o_level_req[x.src], o_edge_req[x.src], x.rect, x.lvl, x.edg);
        end
      end
    end
  endtask

  task automatic test_all_sources();
    int e;
    logic [N-1:0] want;
    clean_reset(4'd0);
    for (int i = 0; i < N; i++) set_sm(i, SM_EDGE1);
    repeat (3) tick();
    e = cyc;
    irq = '1;
    for (int k = 0; k < 8; k++) begin
      tick();
      want = (cyc == e + 4) ? '1 : '0;
      total++;
      if (o_edge_req !== want) begin
        bad++;
        $display("FAIL all_sources cyc=%0d got edge=%h required %h", cyc, o_edge_req, want);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    irq  = '0;
    sm   = '0;
    flen = '0;
    test_reset();
    test_edge_latency();
    test_filter();
    test_level0();
    test_mode_switch();
    test_reset_mid_filter();
    test_back_to_back();
    test_all_sources();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
